// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared state/op types and limits for the LC-3 memory access unit
package lc3_mem_pkg;
  localparam int MAX_WAIT = 15;
  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_GAP, RD, WR, WR_HOLD, DONE} mem_state_t;
  typedef enum logic {READ, WRITE} mem_op_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-state counter shared by every strobe state; flags the final strobe cycle
module mem_wait_timer
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic last_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last_o = cnt_q == CW'(WAIT_CYCLES - 1);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: owns MAR/MDR and sequences wait-stated async SRAM reads, writes and indirect accesses
module mem_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req,
  input  logic              we,
  input  logic              indirect,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);
  mem_state_t state_q, state_d;
  mem_op_t op_q, op_d;
  logic [DATA_W-1:0] mar_q, mar_d, mdr_q, mdr_d, rdata_q, rdata_d;
  logic last;
  mem_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clear_i(state_d != state_q),
    .en_i   (state_q inside {PTR_RD, RD, WR}),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        mar_d = addr_in;
        mdr_d = wdata;
        op_d = we ? WRITE : READ;
        state_d = indirect ? PTR_RD : we ? WR : RD;
      end
      PTR_RD: if (last) begin
        mar_d = mem_rdata;
        state_d = PTR_GAP;
      end
      PTR_GAP: state_d = op_q == WRITE ? WR : RD;
      RD: if (last) begin
        mdr_d = mem_rdata;
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      WR: state_d = last ? WR_HOLD : WR;
      WR_HOLD: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q <= READ;
      mar_q <= '0;
      mdr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      rdata_q <= rdata_d;
    end
  // Strobes decode straight from the state so an async reset releases them instantly
  assign mem_ce_n = !(state_q inside {PTR_RD, RD, WR, WR_HOLD});
  assign mem_oe_n = !(state_q inside {PTR_RD, RD});
  assign mem_we_n = state_q != WR;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign rdata = rdata_q;
  assign mem_addr = mar_q;
  assign mem_wdata = mdr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of reads, writes, indirect, back-to-back and mid-write reset
module tb_mem_access_unit;
  logic Clk = 0, Reset_n = 0, req = 0, we = 0, indirect = 0;
  logic [15:0] addr_in = 0, wdata = 0, rdata, mem_addr, mem_wdata, mem_rdata;
  logic busy, done, mem_ce_n, mem_oe_n, mem_we_n;
  logic [15:0] sram [0:65535];
  int total = 0, bad = 0, overlap = 0;
  int lat, oe_c, we_c, hold_c, gap_c;
  logic [15:0] last_a;
  logic stable;
  int first_done, acc2, second_done;

  mem_access_unit #(.WAIT_CYCLES(2), .DATA_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .we(we), .indirect(indirect),
    .addr_in(addr_in), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 Clk = ~Clk;
  assign mem_rdata = sram[mem_addr];
  always @(posedge Clk) if (!mem_ce_n && !mem_we_n) sram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic ind, input logic [15:0] a, input logic [15:0] d,
                        output int lt, output int oc, output int wc, output int hc, output int gc,
                        output logic [15:0] la, output logic st);
    logic [15:0] wa, wd;
    logic seen;
    lt = 0; oc = 0; wc = 0; hc = 0; gc = 0; la = 'x; st = 1; seen = 0; wa = 0; wd = 0;
    @(negedge Clk);
    req = 1; we = w; indirect = ind; addr_in = a; wdata = d;
    @(negedge Clk);
    req = 0;
    for (int i = 0; i < 50; i++) begin
      lt++;
      if (done) break;
      if (!mem_oe_n && !mem_we_n) overlap++;
      if (!mem_oe_n) oc++;
      if (!mem_we_n) wc++;
      if (!mem_ce_n && mem_we_n && mem_oe_n) hc++;
      if (busy && mem_ce_n) gc++;
      if (!mem_ce_n) la = mem_addr;
      if (!mem_ce_n && mem_oe_n) begin
        if (!seen) begin wa = mem_addr; wd = mem_wdata; seen = 1; end
        else if (mem_addr !== wa || mem_wdata !== wd) st = 0;
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    sram[16'h3000] = 16'hBEEF;
    sram[16'hFFFF] = 16'h1357;
    sram[16'h0000] = 16'h0000;
    repeat (3) @(negedge Clk);
    chk("rst_we_n", mem_we_n, 1);
    Reset_n = 1;
    @(negedge Clk);
    chk("idle_ce_n", mem_ce_n, 1);
    chk("idle_oe_n", mem_oe_n, 1);
    chk("idle_we_n", mem_we_n, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_rdata", rdata, 16'h0000);
    chk("idle_addr", mem_addr, 16'h0000);

    access(0, 0, 16'h3000, 16'h0000, lat, oe_c, we_c, hold_c, gap_c, last_a, stable);
    chk("rd_lat", lat, 3);
    chk("rd_oe_cycles", oe_c, 2);
    chk("rd_we_cycles", we_c, 0);
    chk("rd_addr", last_a, 16'h3000);
    chk("rd_rdata", rdata, 16'hBEEF);

    access(1, 0, 16'h4010, 16'h1234, lat, oe_c, we_c, hold_c, gap_c, last_a, stable);
    chk("wr_lat", lat, 4);
    chk("wr_we_cycles", we_c, 2);
    chk("wr_oe_cycles", oe_c, 0);
    chk("wr_hold_cycles", hold_c, 1);
    chk("wr_stable", stable, 1);
    chk("wr_sram", sram[16'h4010], 16'h1234);
    chk("wr_rdata_kept", rdata, 16'hBEEF);

    sram[16'h3000] = 16'h5000;
    sram[16'h5000] = 16'hA5A5;
    access(0, 1, 16'h3000, 16'h0000, lat, oe_c, we_c, hold_c, gap_c, last_a, stable);
    chk("ind_lat", lat, 6);
    chk("ind_oe_cycles", oe_c, 4);
    chk("ind_gap", gap_c, 1);
    chk("ind_addr", last_a, 16'h5000);
    chk("ind_rdata", rdata, 16'hA5A5);

    // req held high: read 0xFFFF, then a write to 0x0000 presented while still busy
    first_done = 0; acc2 = 0; second_done = 0;
    @(negedge Clk);
    req = 1; we = 0; indirect = 0; addr_in = 16'hFFFF;
    @(negedge Clk);
    we = 1; addr_in = 16'h0000; wdata = 16'h2468;
    for (int i = 1; i <= 40; i++) begin
      if (i == 2) chk("b2b_ignore_addr", mem_addr, 16'hFFFF);
      if (done && first_done == 0) begin
        first_done = i;
        chk("b2b_rdata", rdata, 16'h1357);
      end else if (first_done != 0 && acc2 == 0 && busy) begin
        acc2 = i;
        chk("b2b_wr_addr", mem_addr, 16'h0000);
        chk("b2b_wr_we_n", mem_we_n, 0);
        req = 0;
      end else if (acc2 != 0 && done) begin
        second_done = i;
        break;
      end
      @(negedge Clk);
    end
    chk("b2b_first_done", first_done, 3);
    chk("b2b_idle_gap", acc2 - first_done, 2);
    chk("b2b_wr_lat", second_done - acc2, 3);
    chk("b2b_sram", sram[16'h0000], 16'h2468);
    chk("b2b_rdata_kept", rdata, 16'h1357);

    @(negedge Clk);
    req = 1; we = 1; indirect = 0; addr_in = 16'h4020; wdata = 16'hDEAD;
    @(negedge Clk);
    req = 0;
    chk("mid_we_low", mem_we_n, 0);
    #2 Reset_n = 0;
    #1;
    chk("mid_rst_we_n", mem_we_n, 1);
    chk("mid_rst_ce_n", mem_ce_n, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
    chk("post_rst_busy", busy, 0);
    access(0, 0, 16'h4010, 16'h0000, lat, oe_c, we_c, hold_c, gap_c, last_a, stable);
    chk("post_rd_lat", lat, 3);
    chk("post_rd_rdata", rdata, 16'h1234);
    chk("oe_we_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- LC-3 memory-side consumer of the effective address produced by the address unit. It owns the MAR and MDR registers and sequences single-port asynchronous-SRAM reads and writes with a fixed number of wait states.
- Supports indirect access (LDI/STI): a pointer read, then the real access through the fetched pointer.
- Sits between the datapath/control FSM (req/done handshake) and the physical memory pins.

Parameters:
- WAIT_CYCLES, 2: cycles each strobe (OE_n/WE_n) is held low; legal range 1..15.
- DATA_W, 16: data and address width; fixed at 16 for LC-3.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only while busy=0.
- we  in  1  1 = write, 0 = read; sampled with req.
- indirect  in  1  1 = pointer read first, then access at mem[addr_in]; sampled with req.
- addr_in  in  16  effective address from the address unit.
- wdata  in  16  store data; latched into MDR on acceptance.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  last read result (MDR view).
- mem_addr  out  16  MAR contents.
- mem_wdata  out  16  MDR contents.
- mem_rdata  in  16  SRAM read data.
- mem_ce_n  out  1  chip enable, active low.
- mem_oe_n  out  1  output enable, active low.
- mem_we_n  out  1  write enable, active low.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; counter, MAR, MDR and rdata = 0.
  - busy=0, done=0; mem_ce_n = mem_oe_n = mem_we_n = 1.
  - A reset mid-access deasserts all strobes in the same instant; no partial write is completed.
- States: IDLE, PTR_RD, PTR_GAP, RD, WR, WR_HOLD, DONE.
- IDLE, req=1 at edge T: MAR<=addr_in, MDR<=wdata, op latched.
  - Next state: PTR_RD if indirect, else RD if we=0, else WR.
  - busy=1 from T+1.
- PTR_RD:
  - ce_n=0, oe_n=0 for WAIT_CYCLES cycles.
  - On the last cycle, MAR<=mem_rdata; go to PTR_GAP.
- PTR_GAP: one cycle with all strobes high (bus turnaround); then RD or WR.
- RD:
  - ce_n=0, oe_n=0 for WAIT_CYCLES cycles.
  - On the last cycle, MDR<=mem_rdata and rdata<=mem_rdata; go to DONE.
- WR:
  - ce_n=0, we_n=0, oe_n=1 for WAIT_CYCLES cycles.
  - mem_addr and mem_wdata are stable throughout; go to WR_HOLD.
- WR_HOLD: one cycle, we_n=1, ce_n=0, address and data held (hold time); go to DONE.
- DONE: done=1, busy=1, strobes high; then IDLE.
- oe_n and we_n are never low in the same cycle.
- Latency from the req edge to the done cycle:
  - read: WAIT_CYCLES+1
  - write: WAIT_CYCLES+2
  - indirect: add WAIT_CYCLES+1
- req held high continuously: the next access is accepted in the IDLE cycle after DONE, so there is exactly one idle cycle between accesses. req while busy is ignored, not queued.
- rdata holds its value across writes and idle cycles; it updates only at the end of RD.
- No address arithmetic: 0xFFFF and 0x0000 pass unmodified, including as fetched pointers.
- Counter runs 0..WAIT_CYCLES-1 and clears on every state entry.

Decomposition:
- Package lc3_mem_pkg:
  - mem_state_t enum (the seven states)
  - mem_op_t (READ, WRITE)
  - localparam MAX_WAIT = 15
- Sub-module mem_wait_timer:
  - Inputs: clear/enable.
  - Output: 'last' flag when count == WAIT_CYCLES-1.
  - Instantiated once and shared by all strobe states.

Test Plan:
- Reset, then idle -> all strobes 1, busy=0, done=0, rdata=0x0000, mem_addr=0x0000.
- Read (WAIT_CYCLES=2): req, we=0, addr_in=0x3000; SRAM[0x3000]=0xBEEF -> oe_n low 2 cycles with mem_addr=0x3000; done 3 cycles after req; rdata=0xBEEF.
- Write: req, we=1, addr_in=0x4010, wdata=0x1234 -> we_n low 2 cycles, then 1 hold cycle with addr/data stable; done 4 cycles after req; SRAM[0x4010]=0x1234; rdata unchanged.
- Indirect read: SRAM[0x3000]=0x5000, SRAM[0x5000]=0xA5A5; req, indirect=1, addr_in=0x3000 -> pointer read, gap cycle, mem_addr=0x5000; done 6 cycles after req; rdata=0xA5A5.
- Back-to-back with req held high: read 0xFFFF then write 0x0000 -> exactly one idle cycle between the first done and the second acceptance; req asserted while busy is ignored.
- Reset_n pulsed low during WR with we_n=0 -> we_n=1 immediately (asynchronously); state IDLE; target word not compared; next read operates normally.
